// File: rtl/music_sequencer.sv
// Score playback controller: steps a combinational score ROM one beat per TICK_DIV cycles and
// drives registered per-channel note dividers and volume. Define SEQ_LOOP_EN for seamless looping.
module music_sequencer #(
  parameter int unsigned TICK_DIV   = 12_500_000,
  parameter int unsigned GAP_CYCLES = 500_000,
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned SONG_LEN   = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play,
  input  logic              rewind,
  input  logic              vol_up,
  input  logic              vol_down,
  output logic [ADDR_W-1:0] beat_addr,
  input  logic [21:0]       rom_div_left,
  input  logic [21:0]       rom_div_right,
  output logic [21:0]       note_div_left,
  output logic [21:0]       note_div_right,
  output logic [2:0]        volume,
  output logic              done
);

  localparam int unsigned       CntW     = $clog2(TICK_DIV);
  localparam logic [CntW-1:0]   TickLast = CntW'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] AddrLast = ADDR_W'(SONG_LEN - 1);
  localparam logic [21:0]       Silence  = 22'd1;

  typedef enum logic [1:0] {StIdle, StPlay, StPause, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [ADDR_W-1:0] beat_addr_q, beat_addr_d;
  logic [21:0]       note_l_q, note_l_d, note_r_q, note_r_d;
  logic [2:0]        vol_q, vol_d;
  logic              done_q, done_d;
  logic              in_gap;

  // Compared at 32 bits so GAP_CYCLES = 0 never matches, whatever CntW is.
  assign in_gap = (32'(tick_cnt_q) >= (TICK_DIV - GAP_CYCLES));

  function automatic logic [21:0] map_note(input logic [21:0] rom, input logic gap);
    return ((rom == 22'd0) || gap) ? Silence : rom;
  endfunction

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    beat_addr_d = beat_addr_q;
    note_l_d    = Silence;
    note_r_d    = Silence;
    if (rewind) begin
      state_d     = StIdle;
      tick_cnt_d  = '0;
      beat_addr_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          tick_cnt_d  = '0;
          beat_addr_d = '0;
          if (play) state_d = StPlay;
        end
        StPlay: begin
          if (!play) begin
            state_d = StPause;
          end else begin
            note_l_d = map_note(rom_div_left, in_gap);
            note_r_d = map_note(rom_div_right, in_gap);
            if (tick_cnt_q == TickLast) begin
              tick_cnt_d = '0;
              if (beat_addr_q == AddrLast) begin
`ifdef SEQ_LOOP_EN
                beat_addr_d = '0;
`else
                state_d = StDone;
`endif
              end else begin
                beat_addr_d = beat_addr_q + 1'b1;
              end
            end else begin
              tick_cnt_d = tick_cnt_q + 1'b1;
            end
          end
        end
        StPause: begin
          if (play) state_d = StPlay;
        end
        StDone: begin
          state_d = StDone;
        end
        default: state_d = StIdle;
      endcase
    end
    done_d = (state_d == StDone);
  end

  // Simultaneous up and down cancel out.
  always_comb begin
    vol_d = vol_q;
    if (vol_up && !vol_down && (vol_q != 3'd7)) begin
      vol_d = vol_q + 3'd1;
    end else if (vol_down && !vol_up && (vol_q != 3'd0)) begin
      vol_d = vol_q - 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      tick_cnt_q  <= '0;
      beat_addr_q <= '0;
      note_l_q    <= Silence;
      note_r_q    <= Silence;
      vol_q       <= 3'd3;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      beat_addr_q <= beat_addr_d;
      note_l_q    <= note_l_d;
      note_r_q    <= note_r_d;
      vol_q       <= vol_d;
      done_q      <= done_d;
    end
  end

  assign beat_addr      = beat_addr_q;
  assign note_div_left  = note_l_q;
  assign note_div_right = note_r_q;
  assign volume         = vol_q;
  assign done           = done_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Scoreboard bench for music_sequencer: TICK_DIV=10, GAP_CYCLES=2, SONG_LEN=4, non-looping build.
module tb_music_sequencer;

  logic        clk = 1'b0;
  logic        rst, play, rewind, vol_up, vol_down;
  logic [6:0]  beat_addr;
  logic [21:0] rom_l, rom_r, note_l, note_r;
  logic [2:0]  volume;
  logic        done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [6:0]  addr;
    logic [21:0] l;
    logic [21:0] r;
    logic [2:0]  v;
    logic        d;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  music_sequencer #(
    .TICK_DIV  (10),
    .GAP_CYCLES(2),
    .ADDR_W    (7),
    .SONG_LEN  (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .play          (play),
    .rewind        (rewind),
    .vol_up        (vol_up),
    .vol_down      (vol_down),
    .beat_addr     (beat_addr),
    .rom_div_left  (rom_l),
    .rom_div_right (rom_r),
    .note_div_left (note_l),
    .note_div_right(note_r),
    .volume        (volume),
    .done          (done)
  );

  // Score ROM
  always_comb begin
    rom_l = 22'd0;
    rom_r = 22'd0;
    case (beat_addr)
      7'd0: begin rom_l = 22'd1000; rom_r = 22'd0;   end
      7'd1: begin rom_l = 22'd0;    rom_r = 22'd500; end
      7'd2: begin rom_l = 22'd2000; rom_r = 22'd600; end
      7'd3: begin rom_l = 22'd3000; rom_r = 22'd0;   end
      default: ;
    endcase
  end

  task automatic chk(input string name, input string field, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s.%s actual=%0d required=%0d", name, field, act, req);
    end
  endtask

  // Monitor: compare the DUT against each queued expectation on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "beat_addr", int'(beat_addr), int'(e.addr));
      chk(e.name, "note_l", int'(note_l), int'(e.l));
      chk(e.name, "note_r", int'(note_r), int'(e.r));
      chk(e.name, "volume", int'(volume), int'(e.v));
      chk(e.name, "done", int'(done), int'(e.d));
    end
  end

  task automatic expect_out(input string name, input int addr, input int l, input int r,
                            input int v, input int d);
    exp_t e;
    e.name = name;
    e.addr = 7'(addr);
    e.l    = 22'(l);
    e.r    = 22'(r);
    e.v    = 3'(v);
    e.d    = d[0];
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int up_exp[5]   = '{4, 5, 6, 7, 7};
  int down_exp[9] = '{6, 5, 4, 3, 2, 1, 0, 0, 0};

  initial begin
    rst = 1'b1; play = 1'b0; rewind = 1'b0; vol_up = 1'b0; vol_down = 1'b0;
    step(3);
    expect_out("reset", 0, 1, 1, 3, 0);
    rst  = 1'b0;
    play = 1'b1;
    step(1);  expect_out("play_entry", 0, 1, 1, 3, 0);
    step(1);  expect_out("beat0_first", 0, 1000, 1, 3, 0);
    step(7);  expect_out("beat0_last_tone", 0, 1000, 1, 3, 0);
    step(1);  expect_out("gap_start", 0, 1, 1, 3, 0);
    step(1);  expect_out("beat1_start", 1, 1, 1, 3, 0);
    step(1);  expect_out("beat1_rest", 1, 1, 500, 3, 0);
    step(8);  expect_out("beat1_gap", 1, 1, 1, 3, 0);
    step(2);  expect_out("beat2", 2, 2000, 600, 3, 0);
    step(13); expect_out("beat3_t3", 3, 3000, 1, 3, 0);
    play = 1'b0;
    step(1);  expect_out("pause_silent", 3, 1, 1, 3, 0);
    step(49); expect_out("pause_hold", 3, 1, 1, 3, 0);
    play = 1'b1;
    step(1);  expect_out("resume_state", 3, 1, 1, 3, 0);
    step(1);  expect_out("resume_tone", 3, 3000, 1, 3, 0);
    step(3);  expect_out("resume_t7", 3, 3000, 1, 3, 0);
    step(1);  expect_out("last_gap", 3, 1, 1, 3, 0);
    step(1);  expect_out("done", 3, 1, 1, 3, 1);
    play = 1'b0;
    step(2);
    play = 1'b1;
    step(2);  expect_out("done_play_ignored", 3, 1, 1, 3, 1);
    play   = 1'b0;
    rewind = 1'b1;
    step(1);  expect_out("rewind_from_done", 0, 1, 1, 3, 0);
    rewind = 1'b0;
    step(3);  expect_out("idle_hold", 0, 1, 1, 3, 0);

    for (int i = 0; i < 5; i++) begin
      vol_up = 1'b1;
      step(1);
      vol_up = 1'b0;
      expect_out("vol_up", 0, 1, 1, up_exp[i], 0);
    end
    vol_up = 1'b1; vol_down = 1'b1;
    step(1);
    vol_up = 1'b0; vol_down = 1'b0;
    expect_out("vol_both", 0, 1, 1, 7, 0);
    for (int i = 0; i < 9; i++) begin
      vol_down = 1'b1;
      step(1);
      vol_down = 1'b0;
      expect_out("vol_down", 0, 1, 1, down_exp[i], 0);
    end

    play = 1'b1;
    step(5);  expect_out("replay_t3", 0, 1000, 1, 0, 0);
    step(5);  expect_out("replay_t9", 0, 1, 1, 0, 0);
    rewind = 1'b1;
    step(1);
    rewind = 1'b0;
    play   = 1'b0;
    expect_out("rewind_beats_advance", 0, 1, 1, 0, 0);
    step(2);  expect_out("rewind_idle", 0, 1, 1, 0, 0);

    vol_up = 1'b1;
    step(1);
    vol_up = 1'b0;
    play   = 1'b1;
    step(4);  expect_out("prereset", 0, 1000, 1, 1, 0);
    step(1);
    rst  = 1'b1;
    play = 1'b0;
    expect_out("async_reset", 0, 1, 1, 3, 0);
    step(2);
    rst = 1'b0;
    step(2);  expect_out("post_reset", 0, 1, 1, 3, 0);

    step(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drained actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
